// File: rtl/debug_pkg.sv
// Shared definitions for the host debug controller: command bytes, FSM states, dump geometry.
package debug_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;

    localparam int DUMP_WORDS     = 34;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        LOAD,
        SEND
    } state_t;

endpackage

// File: rtl/debug_word_serializer.sv
// Word-to-byte serializer: loads one word, then emits it LSB byte first over a valid/ready handshake.
module debug_word_serializer
    import debug_pkg::*;
#(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [NB_WORD-1:0] load_data,
    input  logic               ready,
    output logic [NB_BYTE-1:0] data,
    output logic               valid,
    output logic               word_done
);

    localparam int NB_BYTE_IDX = $clog2(BYTES_PER_WORD);
    localparam logic [NB_BYTE_IDX-1:0] LAST_BYTE = NB_BYTE_IDX'(BYTES_PER_WORD - 1);

    logic [NB_WORD-1:0]     shift;
    logic [NB_BYTE_IDX-1:0] byte_idx;

    assign data      = shift[NB_BYTE-1:0];
    assign word_done = valid && ready && (byte_idx == LAST_BYTE);

    // The byte index wraps back to zero on the last handshake, ready for the next load.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift    <= '0;
            byte_idx <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            shift    <= load_data;
            byte_idx <= '0;
            valid    <= 1'b1;
        end else if (valid && ready) begin
            shift    <= shift >> NB_BYTE;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == LAST_BYTE) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/debug_unit.sv
// Host debug controller for the MIPS pipeline: run/step/dump commands and snapshot serialization.
// Optional RUN watchdog enabled by defining DEBUG_UNIT_WATCHDOG_EN.
module debug_unit
    import debug_pkg::*;
#(
    parameter int NB_REG        = 32,
    parameter int NB_REG_ADDR   = 5,
    parameter int REGFILE_DEPTH = 32,
    parameter int NB_BYTE       = 8,
    parameter int WDOG_CYCLES   = 4096
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NB_BYTE-1:0]     i_rx_data,
    input  logic                   i_rx_valid,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_pipe_valid,
    input  logic                   i_halt,
    input  logic [NB_REG-1:0]      i_pc,
    output logic [NB_REG_ADDR-1:0] o_rf_addr,
    input  logic [NB_REG-1:0]      i_rf_data,
    output logic [NB_REG-1:0]      o_n_clocks
);

    localparam int NB_WORD_IDX = $clog2(DUMP_WORDS);
    localparam logic [NB_WORD_IDX-1:0] LAST_WORD  = NB_WORD_IDX'(REGFILE_DEPTH + 1);
    localparam logic [NB_REG-1:0]      COUNT_MAX  = '1;

    state_t                 state;
    logic                   halted;
    logic [NB_WORD_IDX-1:0] word_idx;
    logic [NB_REG-1:0]      snap_pc;
    logic [NB_REG-1:0]      snap_count;
    logic [NB_REG-1:0]      n_clocks_next;
    logic [NB_REG-1:0]      load_word;
    logic                   word_done;
    logic [NB_REG-1:0]      o_n_clocks_q;

`ifdef DEBUG_UNIT_WATCHDOG_EN
    localparam int NB_WDOG = $clog2(WDOG_CYCLES) + 1;
    localparam logic [NB_WDOG-1:0] WDOG_LAST = NB_WDOG'(WDOG_CYCLES - 1);
    logic [NB_WDOG-1:0] wdog_count;
`endif

    assign o_pipe_valid  = (state == RUN) || (state == STEP);
    assign o_n_clocks    = o_n_clocks_q;
    assign n_clocks_next = (o_pipe_valid && (o_n_clocks_q != COUNT_MAX)) ? o_n_clocks_q + 1'b1
                                                                          : o_n_clocks_q;
    assign o_rf_addr     = (word_idx >= NB_WORD_IDX'(2)) ? NB_REG_ADDR'(word_idx - NB_WORD_IDX'(2))
                                                          : '0;

    always_comb begin
        load_word = i_rf_data;
        if (word_idx == NB_WORD_IDX'(0)) begin
            load_word = snap_pc;
        end else if (word_idx == NB_WORD_IDX'(1)) begin
            load_word = snap_count;
        end
    end

    // Snapshots take the post-increment count so the cycle that leaves RUN/STEP is included.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= IDLE;
            halted       <= 1'b0;
            o_n_clocks_q <= '0;
            word_idx     <= '0;
            snap_pc      <= '0;
            snap_count   <= '0;
`ifdef DEBUG_UNIT_WATCHDOG_EN
            wdog_count   <= '0;
`endif
        end else begin
            o_n_clocks_q <= n_clocks_next;
            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_RUN, CMD_STEP: begin
                                if (halted) begin
                                    state      <= LOAD;
                                    snap_pc    <= i_pc;
                                    snap_count <= n_clocks_next;
                                end else begin
                                    state <= (i_rx_data == CMD_RUN) ? RUN : STEP;
`ifdef DEBUG_UNIT_WATCHDOG_EN
                                    wdog_count <= '0;
`endif
                                end
                            end
                            CMD_DUMP: begin
                                state      <= LOAD;
                                snap_pc    <= i_pc;
                                snap_count <= n_clocks_next;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (i_halt) begin
                        halted     <= 1'b1;
                        state      <= LOAD;
                        snap_pc    <= i_pc;
                        snap_count <= n_clocks_next;
`ifdef DEBUG_UNIT_WATCHDOG_EN
                    end else if (wdog_count == WDOG_LAST) begin
                        state      <= LOAD;
                        snap_pc    <= i_pc;
                        snap_count <= n_clocks_next;
                    end else begin
                        wdog_count <= wdog_count + 1'b1;
`endif
                    end
                end
                STEP: begin
                    if (i_halt) begin
                        halted <= 1'b1;
                    end
                    state      <= LOAD;
                    snap_pc    <= i_pc;
                    snap_count <= n_clocks_next;
                end
                LOAD: begin
                    state <= SEND;
                end
                SEND: begin
                    if (word_done) begin
                        if (word_idx == LAST_WORD) begin
                            word_idx <= '0;
                            state    <= IDLE;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                            state    <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    debug_word_serializer #(
        .NB_WORD (NB_REG),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .clock     (i_clock),
        .reset     (i_reset),
        .load      (state == LOAD),
        .load_data (load_word),
        .ready     (i_tx_ready),
        .data      (o_tx_data),
        .valid     (o_tx_valid),
        .word_done (word_done)
    );

endmodule

// File: tb/tb_debug_unit.sv
// Directed self-checking bench for debug_unit; extra watchdog steps when DEBUG_UNIT_WATCHDOG_EN is defined.
module tb_debug_unit;
    import debug_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        pipe_valid;
    logic        halt;
    logic [31:0] pc;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] n_clocks;

    int n_checks = 0;
    int n_errors = 0;
    int valid_total = 0;
    int base_valid;
    int rx_count;
    int stall_errors;
    logic tail_valid;
    logic [31:0] rx_words [DUMP_WORDS];
    bit ready_pattern [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clock = ~clock;

    // Register k of the modelled register file holds the value k.
    assign rf_data = {27'b0, rf_addr};

    always @(negedge clock) begin
        if (pipe_valid === 1'b1) valid_total++;
    end

    debug_unit #(
        .WDOG_CYCLES (16)
    ) dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_pipe_valid (pipe_valid),
        .i_halt       (halt),
        .i_pc         (pc),
        .o_rf_addr    (rf_addr),
        .i_rf_data    (rf_data),
        .o_n_clocks   (n_clocks)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] cmd);
        @(negedge clock);
        rx_data  = cmd;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    // Collects 136 accepted bytes, optionally throttling ready and injecting a 'S' mid-dump.
    task automatic collectDump(input bit use_pattern, input bit inject);
        int cycles = 0;
        int pat_idx = 0;
        bit have_prev = 1'b0;
        logic [7:0] prev_data = '0;
        rx_count = 0;
        stall_errors = 0;
        for (int w = 0; w < DUMP_WORDS; w++) rx_words[w] = 32'hDEAD_BEEF;
        while (rx_count < DUMP_WORDS * BYTES_PER_WORD && cycles < 3000) begin
            @(negedge clock);
            cycles++;
            tx_ready = use_pattern ? ready_pattern[pat_idx % 6] : 1'b1;
            pat_idx++;
            if (inject && rx_count == 20) begin
                rx_data  = CMD_STEP;
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            if (have_prev && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_errors++;
            have_prev = (tx_valid === 1'b1) && !tx_ready;
            prev_data = tx_data;
            if (tx_valid === 1'b1 && tx_ready) begin
                rx_words[rx_count / 4][8 * (rx_count % 4) +: 8] = tx_data;
                rx_count++;
            end
        end
        rx_valid = 1'b0;
        @(negedge clock);
        tail_valid = tx_valid;
        tx_ready = 1'b1;
    endtask

    task automatic checkDump(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_count);
        checkOutput({tag, "_bytes"}, rx_count, DUMP_WORDS * BYTES_PER_WORD);
        checkOutput({tag, "_stall"}, stall_errors, 0);
        checkOutput({tag, "_tail_valid"}, {31'b0, tail_valid}, 0);
        checkOutput({tag, "_pc"}, rx_words[0], exp_pc);
        checkOutput({tag, "_count"}, rx_words[1], exp_count);
        for (int w = 2; w < DUMP_WORDS; w++) begin
            checkOutput($sformatf("%s_reg%0d", tag, w - 2), rx_words[w], w - 2);
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int seen;
        reset    = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        halt     = 1'b0;
        pc       = 32'h0000_0040;
        repeat (3) @(negedge clock);
        checkOutput("rst_pipe_valid", {31'b0, pipe_valid}, 0);
        checkOutput("rst_tx_valid", {31'b0, tx_valid}, 0);
        checkOutput("rst_tx_data", {24'b0, tx_data}, 0);
        checkOutput("rst_rf_addr", {27'b0, rf_addr}, 0);
        checkOutput("rst_n_clocks", n_clocks, 0);
        reset = 1'b0;

        $display("[TB] plain dump");
        base_valid = valid_total;
        applyStimulus(CMD_DUMP);
        collectDump(1'b0, 1'b0);
        checkDump("dump", 32'h0000_0040, 0);
        checkOutput("dump_no_valid", valid_total - base_valid, 0);

        $display("[TB] single step");
        pc = 32'h0000_0044;
        base_valid = valid_total;
        applyStimulus(CMD_STEP);
        collectDump(1'b0, 1'b0);
        checkDump("step", 32'h0000_0044, 1);
        checkOutput("step_valid_cycles", valid_total - base_valid, 1);
        checkOutput("step_n_clocks", n_clocks, 1);

        $display("[TB] unknown byte");
        base_valid = valid_total;
        applyStimulus(8'h58);
        repeat (5) @(negedge clock);
        checkOutput("unknown_tx_valid", {31'b0, tx_valid}, 0);
        checkOutput("unknown_valid_cycles", valid_total - base_valid, 0);
        checkOutput("unknown_n_clocks", n_clocks, 1);

        $display("[TB] command during send");
        base_valid = valid_total;
        applyStimulus(CMD_DUMP);
        collectDump(1'b0, 1'b1);
        checkDump("inject", 32'h0000_0044, 1);
        checkOutput("inject_valid_cycles", valid_total - base_valid, 0);
        repeat (3) @(negedge clock);
        checkOutput("inject_idle_after", {31'b0, tx_valid}, 0);

        $display("[TB] reset mid-send");
        applyStimulus(CMD_DUMP);
        repeat (8) @(negedge clock);
        checkOutput("midsend_active", {31'b0, tx_valid}, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midsend_rst_tx_valid", {31'b0, tx_valid}, 0);
        checkOutput("midsend_rst_tx_data", {24'b0, tx_data}, 0);
        checkOutput("midsend_rst_rf_addr", {27'b0, rf_addr}, 0);
        checkOutput("midsend_rst_n_clocks", n_clocks, 0);
        repeat (4) @(negedge clock);
        checkOutput("midsend_abandoned", {31'b0, tx_valid}, 0);

        $display("[TB] run until halt with throttled ready");
        pc = 32'h0000_0100;
        base_valid = valid_total;
        applyStimulus(CMD_RUN);
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (pipe_valid === 1'b1) seen++;
            if (seen == 10) begin
                halt = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checkOutput("run_reached_10", seen, 10);
        @(negedge clock);
        halt = 1'b0;
        checkOutput("run_stopped", {31'b0, pipe_valid}, 0);
        collectDump(1'b1, 1'b0);
        checkDump("run", 32'h0000_0100, 10);
        checkOutput("run_valid_cycles", valid_total - base_valid, 10);
        checkOutput("run_n_clocks", n_clocks, 10);

        $display("[TB] run after halt");
        base_valid = valid_total;
        applyStimulus(CMD_RUN);
        collectDump(1'b0, 1'b0);
        checkDump("rerun", 32'h0000_0100, 10);
        checkOutput("rerun_valid_cycles", valid_total - base_valid, 0);
        checkOutput("rerun_n_clocks", n_clocks, 10);

`ifdef DEBUG_UNIT_WATCHDOG_EN
        $display("[TB] watchdog");
        doReset();
        pc = 32'h0000_0200;
        base_valid = valid_total;
        applyStimulus(CMD_RUN);
        collectDump(1'b0, 1'b0);
        checkDump("wdog1", 32'h0000_0200, 16);
        checkOutput("wdog1_valid_cycles", valid_total - base_valid, 16);
        base_valid = valid_total;
        applyStimulus(CMD_RUN);
        collectDump(1'b0, 1'b0);
        checkDump("wdog2", 32'h0000_0200, 32);
        checkOutput("wdog2_valid_cycles", valid_total - base_valid, 16);
`else
        doReset();
        checkOutput("final_rst_n_clocks", n_clocks, 0);
`endif

        $display("[TB] Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
